// File: rtl/led_event_scheduler.sv
// led_event_scheduler
//   Owns the 16 board LEDs. Game logic raises short animation requests
//   (wicket, four, six) and a game_over level; this block queues one pending
//   request per type, picks the winner by fixed priority and steps the chosen
//   animation on an internal tick derived from clk_fpga. With nothing active
//   the LEDs show the static idle pattern from the score path.
//
//   Priority (highest first): game_over > wicket > six > four > idle.
//
// Parameters
//   TICK_DIV      clk_fpga cycles per animation step (>= 2)
//   WICKET_STEPS  flash frames in the wicket animation (even, >= 2)
//
// Ports
//   clk_fpga      system clock
//   rst           synchronous active-high reset
//   idle_pattern  pattern shown while idle
//   req_wicket    1-cycle request pulse: wicket fell
//   req_four      1-cycle request pulse: boundary four
//   req_six       1-cycle request pulse: boundary six
//   game_over     level, celebration runs while high
//   led           registered LED drive
//   busy          high while an animation state is active
//   anim_done     1-cycle pulse when wicket/four/six completes normally
module led_event_scheduler #(
  parameter int TICK_DIV     = 10000000,
  parameter int WICKET_STEPS = 6
) (
  input  logic        clk_fpga,
  input  logic        rst,
  input  logic [15:0] idle_pattern,
  input  logic        req_wicket,
  input  logic        req_four,
  input  logic        req_six,
  input  logic        game_over,
  output logic [15:0] led,
  output logic        busy,
  output logic        anim_done
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (WICKET_STEPS > 2) ? $clog2(WICKET_STEPS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(WICKET_STEPS - 1);

  typedef enum logic [1:0] {IDLE, WICKET, BOUNDARY, CELEBRATE} state_t;

  typedef struct packed {
    logic wicket;
    logic six;
    logic four;
  } pend_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] step_cnt;
  logic          six_run;      // current boundary animation is a six
  logic          second_pass;  // six has wrapped once already
  pend_t         pend;

  logic  tick;
  pend_t pend_set;    // pending flags with this cycle's pulses folded in
  pend_t start_pend;  // pend_set with the winner removed

  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    pend_set        = pend;
    pend_set.wicket = pend.wicket | req_wicket;
    pend_set.six    = pend.six    | req_six;
    pend_set.four   = pend.four   | req_four;
    start_pend      = pend_set;
    if (pend_set.wicket)   start_pend.wicket = 1'b0;
    else if (pend_set.six) start_pend.six    = 1'b0;
    else                   start_pend.four   = 1'b0;
  end

  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state       <= IDLE;
      led         <= '0;
      busy        <= 1'b0;
      anim_done   <= 1'b0;
      tick_cnt    <= '0;
      step_cnt    <= '0;
      six_run     <= 1'b0;
      second_pass <= 1'b0;
      pend        <= '0;
    end else begin
      anim_done <= 1'b0;
      pend      <= pend_set;
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);

      case (state)
        IDLE: begin
          // Counters are held at zero here so every animation starts fresh.
          led         <= idle_pattern;
          busy        <= 1'b0;
          tick_cnt    <= '0;
          step_cnt    <= '0;
          second_pass <= 1'b0;
          if (game_over) begin
            state <= CELEBRATE;
            led   <= '0;
            busy  <= 1'b1;
          end else if (pend_set.wicket) begin
            state <= WICKET;
            led   <= 16'hFFFF;
            busy  <= 1'b1;
            pend  <= start_pend;
          end else if (pend_set.six || pend_set.four) begin
            state   <= BOUNDARY;
            led     <= 16'h0001;
            busy    <= 1'b1;
            six_run <= pend_set.six;
            pend    <= start_pend;
          end
        end

        WICKET: begin
          if (game_over) begin
            // Preempted: animation is dropped, no completion pulse.
            state    <= CELEBRATE;
            led      <= '0;
            tick_cnt <= '0;
          end else if (tick) begin
            if (step_cnt == STEP_LAST) begin
              state     <= IDLE;
              led       <= idle_pattern;
              busy      <= 1'b0;
              anim_done <= 1'b1;
            end else begin
              led      <= ~led;
              step_cnt <= step_cnt + SW'(1);
            end
          end
        end

        BOUNDARY: begin
          if (game_over) begin
            state    <= CELEBRATE;
            led      <= '0;
            tick_cnt <= '0;
          end else if (tick) begin
            if (led == 16'h8000) begin
              if (six_run && !second_pass) begin
                led         <= 16'h0001;
                second_pass <= 1'b1;
              end else begin
                state     <= IDLE;
                led       <= idle_pattern;
                busy      <= 1'b0;
                anim_done <= 1'b1;
              end
            end else begin
              led <= {led[14:0], 1'b0};
            end
          end
        end

        CELEBRATE: begin
          if (!game_over) begin
            // Anything queued during the celebration is stale: drop it.
            state <= IDLE;
            led   <= idle_pattern;
            busy  <= 1'b0;
            pend  <= '0;
          end else if (tick) begin
            if (led == 16'hFFFF) led <= 16'hFFFE;
            else                 led <= {led[14:0], 1'b1};
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_event_scheduler.sv
// Bench for led_event_scheduler with TICK_DIV=4, WICKET_STEPS=6.
// Each scenario pushes the expected per-cycle {led,busy,anim_done} stream to
// a scoreboard queue, then pops and compares one entry per clock.
module tb_led_event_scheduler;

  localparam int TD = 4;
  localparam int WS = 6;

  logic        clk_fpga = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] idle_pattern = 16'h00A5;
  logic        req_wicket = 1'b0;
  logic        req_four = 1'b0;
  logic        req_six = 1'b0;
  logic        game_over = 1'b0;
  logic [15:0] led;
  logic        busy;
  logic        anim_done;

  int checks = 0;
  int failures = 0;
  logic [17:0] sb[$];
  logic [17:0] e;
  int dones;
  int n;

  led_event_scheduler #(.TICK_DIV(TD), .WICKET_STEPS(WS)) dut (
    .clk_fpga(clk_fpga), .rst(rst), .idle_pattern(idle_pattern),
    .req_wicket(req_wicket), .req_four(req_four), .req_six(req_six),
    .game_over(game_over), .led(led), .busy(busy), .anim_done(anim_done)
  );

  always #5 clk_fpga = ~clk_fpga;

  function automatic void push(logic [15:0] l, logic b, logic d, int cnt);
    for (int i = 0; i < cnt; i++) sb.push_back({l, b, d});
  endfunction

  function automatic void push_wicket();
    for (int f = 0; f < WS; f++) push((f % 2 == 0) ? 16'hFFFF : 16'h0000, 1'b1, 1'b0, TD);
    push(idle_pattern, 1'b0, 1'b1, 1);
  endfunction

  function automatic void push_boundary(int passes);
    logic [15:0] v;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 16; i++) begin
        v = 16'h0001 << i;
        push(v, 1'b1, 1'b0, TD);
      end
    push(idle_pattern, 1'b0, 1'b1, 1);
  endfunction

  task automatic test_reset();
    idle_pattern = 16'h00A5;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_fpga); #1;
      checks++;
      if (led !== 16'h0000 || busy !== 1'b0 || anim_done !== 1'b0) begin
        failures++;
        $display("FAIL reset c=%0d got led=%h busy=%b done=%b exp led=0000 busy=0 done=0", c, led, busy, anim_done);
      end
    end
    rst = 1'b0;
    push(idle_pattern, 1'b0, 1'b0, 3);
    n = sb.size();
    for (int c = 0; c < n; c++) begin
      @(posedge clk_fpga); #1;
      e = sb.pop_front();
      checks++;
      if ({led, busy, anim_done} !== e) begin
        failures++;
        $display("FAIL post_reset c=%0d got led=%h busy=%b done=%b exp led=%h busy=%b done=%b", c, led, busy, anim_done, e[17:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_wicket();
    idle_pattern = 16'h3C3C;
    req_wicket = 1'b1;
    push_wicket();
    push(idle_pattern, 1'b0, 1'b0, 2);
    n = sb.size();
    dones = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_fpga); #1;
      e = sb.pop_front();
      checks++;
      if ({led, busy, anim_done} !== e) begin
        failures++;
        $display("FAIL wicket c=%0d got led=%h busy=%b done=%b exp led=%h busy=%b done=%b", c, led, busy, anim_done, e[17:2], e[1], e[0]);
      end
      if (anim_done === 1'b1) dones++;
      req_wicket = 1'b0;
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL wicket_done_count got %0d exp 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    idle_pattern = 16'h5A5A;
    req_wicket = 1'b1;
    req_four = 1'b1;
    push_wicket();
    push_boundary(1);
    push(idle_pattern, 1'b0, 1'b0, 2);
    n = sb.size();
    dones = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_fpga); #1;
      e = sb.pop_front();
      checks++;
      if ({led, busy, anim_done} !== e) begin
        failures++;
        $display("FAIL back_to_back c=%0d got led=%h busy=%b done=%b exp led=%h busy=%b done=%b", c, led, busy, anim_done, e[17:2], e[1], e[0]);
      end
      if (anim_done === 1'b1) dones++;
      req_wicket = 1'b0;
      req_four = 1'b0;
    end
    checks++;
    if (dones !== 2) begin
      failures++;
      $display("FAIL back_to_back_done_count got %0d exp 2", dones);
    end
  endtask

  task automatic test_six_replay();
    idle_pattern = 16'h1234;
    req_six = 1'b1;
    push_boundary(2);
    push_boundary(2);
    push(idle_pattern, 1'b0, 1'b0, 3);
    n = sb.size();
    dones = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_fpga); #1;
      e = sb.pop_front();
      checks++;
      if ({led, busy, anim_done} !== e) begin
        failures++;
        $display("FAIL six_replay c=%0d got led=%h busy=%b done=%b exp led=%h busy=%b done=%b", c, led, busy, anim_done, e[17:2], e[1], e[0]);
      end
      if (anim_done === 1'b1) dones++;
      req_six = 1'b0;
      if (c == 10 || c == 20) req_six = 1'b1;
    end
    checks++;
    if (dones !== 2) begin
      failures++;
      $display("FAIL six_done_count got %0d exp 2", dones);
    end
  endtask

  task automatic test_game_over();
    logic [15:0] v;
    idle_pattern = 16'hC003;
    req_four = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      v = 16'h0001 << (c / TD);
      push(v, 1'b1, 1'b0, 1);
    end
    push(16'h0000, 1'b1, 1'b0, TD);
    for (int k = 1; k <= 17; k++) begin
      v = (k <= 16) ? 16'((32'd1 << k) - 1) : 16'hFFFE;
      push(v, 1'b1, 1'b0, TD);
    end
    push(idle_pattern, 1'b0, 1'b0, 6);
    n = sb.size();
    dones = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_fpga); #1;
      e = sb.pop_front();
      checks++;
      if ({led, busy, anim_done} !== e) begin
        failures++;
        $display("FAIL game_over c=%0d got led=%h busy=%b done=%b exp led=%h busy=%b done=%b", c, led, busy, anim_done, e[17:2], e[1], e[0]);
      end
      if (anim_done === 1'b1) dones++;
      req_four = 1'b0;
      req_wicket = 1'b0;
      if (c == 20) game_over = 1'b1;
      if (c == 30) req_wicket = 1'b1;
      if (c == 92) game_over = 1'b0;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL game_over_done_count got %0d exp 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    idle_pattern = 16'h0F0F;
    req_wicket = 1'b1;
    for (int c = 0; c < 10; c++) push(((c / TD) % 2 == 0) ? 16'hFFFF : 16'h0000, 1'b1, 1'b0, 1);
    push(16'h0000, 1'b0, 1'b0, 1);
    push(idle_pattern, 1'b0, 1'b0, 30);
    n = sb.size();
    dones = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_fpga); #1;
      e = sb.pop_front();
      checks++;
      if ({led, busy, anim_done} !== e) begin
        failures++;
        $display("FAIL reset_mid c=%0d got led=%h busy=%b done=%b exp led=%h busy=%b done=%b", c, led, busy, anim_done, e[17:2], e[1], e[0]);
      end
      if (anim_done === 1'b1) dones++;
      req_wicket = 1'b0;
      req_four = 1'b0;
      if (c == 5) req_four = 1'b1;
      if (c == 9) rst = 1'b1;
      if (c == 10) rst = 1'b0;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_mid_done_count got %0d exp 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_wicket();
    test_back_to_back();
    test_six_replay();
    test_game_over();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
